// File: rtl/systolic_sched_pkg.sv
// Shared project constants and types for the systolic array scheduler.
// Holds the array size, the RAM address widths and the scheduler state type.
package systolic_sched_pkg;

    localparam int SYS_CLK_FREQ = 50_000_000;
    localparam int N_DIM        = 2;
    localparam int OPND_AW      = 8;
    localparam int RES_AW       = 11;
    localparam int CNT_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/systolic_sched_cnt.sv
// Loadable 9-bit down-counter with terminal flag.
// It is shared by the FEED and DRAIN phases, and it saturates at zero.
module sched_cnt
    import systolic_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == '0);

endmodule

// File: rtl/systolic_sched.sv
// Sequencer for one systolic matrix product: CLEAR, FEED, DRAIN, WRITE, DONE.
// Outputs decode from the state register, so an asynchronous reset returns them to 0 at once.
module systolic_sched
    import systolic_sched_pkg::*;
#(
    parameter int N         = N_DIM,
    parameter int DRAIN_CYC = 2 * (N - 1) + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            k_len,
    input  logic [RES_AW-1:0]     res_idx,
    input  logic                  abort,
    output logic                  owns_ram,
    output logic [OPND_AW-1:0]    ram_rd_addr,
    output logic                  ram_rden,
    output logic [N-1:0][N-1:0]   en_mult,
    output logic [N-1:0][N-1:0]   clr_mult,
    output logic [N-1:0][N-1:0]   en_accum,
    output logic [N-1:0][N-1:0]   clr_accum,
    output logic [RES_AW-1:0]     ram_c_addr,
    output logic                  ram_c_wren,
    output logic                  busy,
    output logic                  done
);

    sched_state_t        state_q, state_d;
    logic [7:0]          kmax_q, kmax_d;
    logic [RES_AW-1:0]   res_q, res_d;

    logic                cnt_load, cnt_dec, cnt_term;
    logic [CNT_W-1:0]    cnt_load_val, cnt_val;
    logic [CNT_W-1:0]    feed_idx;

    sched_cnt u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .term_o     (cnt_term)
    );

    // The counter runs K-1 down to 0 in FEED, so the read index is its distance from K-1.
    assign feed_idx = {1'b0, kmax_q} - cnt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kmax_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            kmax_q  <= kmax_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        kmax_d       = kmax_q;
        res_d        = res_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        owns_ram     = 1'b0;
        ram_rd_addr  = '0;
        ram_rden     = 1'b0;
        en_mult      = '0;
        clr_mult     = '0;
        en_accum     = '0;
        clr_accum    = '0;
        ram_c_addr   = '0;
        ram_c_wren   = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    kmax_d  = k_len - 8'd1;   // k_len=0 wraps to 255, i.e. K=256
                    res_d   = res_idx;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                owns_ram     = 1'b1;
                clr_mult     = '1;
                clr_accum    = '1;
                cnt_load     = 1'b1;
                cnt_load_val = {1'b0, kmax_q};
                state_d      = ST_FEED;
            end
            ST_FEED: begin
                owns_ram    = 1'b1;
                ram_rden    = 1'b1;
                ram_rd_addr = feed_idx[OPND_AW-1:0];
                // Operands arrive one cycle after the read, so the MACs start one cycle late.
                if (feed_idx != '0) begin
                    en_mult  = '1;
                    en_accum = '1;
                end
                if (cnt_term) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(DRAIN_CYC - 1);
                    state_d      = ST_DRAIN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                owns_ram    = 1'b1;
                ram_rd_addr = kmax_q;
                en_mult     = '1;
                en_accum    = '1;
                if (cnt_term) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WRITE: begin
                ram_c_wren = 1'b1;
                ram_c_addr = res_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                done    = !abort;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

endmodule
